// File: rtl/signed_sar_search.sv
// Binary-search controller that recovers an unknown signed W-bit value
// by driving probes into an external signed "greater than" comparator.
module signed_sar_search #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         cmp_gt,
   output logic [W-1:0] probe,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] result
);

   localparam int unsigned WX = W + 1;
   localparam int unsigned SW = (W > 2) ? $clog2(W) : 1;

   // Search bounds, sign-extended to W+1 bits.
   localparam logic signed [WX-1:0] LO_INIT = {2'b11, {(W-1){1'b0}}};
   localparam logic signed [WX-1:0] HI_INIT = {2'b00, {(W-1){1'b1}}};

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEARCH = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic signed [WX-1:0]   r_lo;
   logic signed [WX-1:0]   r_hi;
   logic signed [WX-1:0]   w_lo_nxt;
   logic signed [WX-1:0]   w_hi_nxt;
   logic signed [WX-1:0]   w_mid;
   logic signed [WX-1:0]   w_mid_nxt;
   logic        [SW-1:0]   r_step;
   logic        [SW-1:0]   w_step_nxt;
   logic        [W-1:0]    r_probe;
   logic                   r_busy;
   logic                   r_done;
   logic        [W-1:0]    r_result;

   // Midpoint rounds toward -inf via arithmetic shift of the W+1-bit sum.
   always_comb begin
      w_mid     = (r_lo + r_hi) >>> 1;
      w_mid_nxt = (w_lo_nxt + w_hi_nxt) >>> 1;
   end

   // Next-state and interval update.
   always_comb begin
      w_state_nxt = r_state;
      w_lo_nxt    = r_lo;
      w_hi_nxt    = r_hi;
      w_step_nxt  = r_step;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_lo_nxt    = LO_INIT;
               w_hi_nxt    = HI_INIT;
               w_step_nxt  = '0;
               w_state_nxt = ST_SEARCH;
            end
         end
         ST_SEARCH: begin
            if (cmp_gt) begin
               w_lo_nxt = w_mid + WX'(1);
            end else begin
               w_hi_nxt = w_mid;
            end
            w_step_nxt = r_step + SW'(1);
            if (r_step == SW'(W - 1)) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_lo    <= '0;
         r_hi    <= '0;
         r_step  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_lo    <= w_lo_nxt;
         r_hi    <= w_hi_nxt;
         r_step  <= w_step_nxt;
      end
   end

   // Outputs are registered from the next state so they line up with it.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_probe  <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_result <= '0;
      end else begin
         r_probe <= (w_state_nxt == ST_SEARCH) ? w_mid_nxt[W-1:0] : '0;
         r_busy  <= (w_state_nxt != ST_IDLE);
         r_done  <= (w_state_nxt == ST_DONE);
         if (w_state_nxt == ST_DONE) begin
            r_result <= w_lo_nxt[W-1:0];
         end
      end
   end

   assign probe  = r_probe;
   assign busy   = r_busy;
   assign done   = r_done;
   assign result = r_result;

endmodule

// File: tb/tb_signed_sar_search.sv
// Directed self-checking bench for signed_sar_search (W=4) with a
// behavioural signed comparator closing the loop.
module tb_signed_sar_search;

   localparam int unsigned W = 4;

   logic               clk;
   logic               reset;
   logic               start;
   logic               cmp_gt;
   logic [W-1:0]       probe;
   logic               busy;
   logic               done;
   logic [W-1:0]       result;
   logic signed [W-1:0] target;

   int checks;
   int failures;

   signed_sar_search #(.W(W)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .cmp_gt (cmp_gt),
      .probe  (probe),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   assign cmp_gt = ($signed(target) > $signed(probe));

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b0;
      start = 1'b1;
      target = 4'sd5;
      repeat (3) tick();
      checks++;
      if (probe !== 4'h0) begin
         failures++;
         $display("FAIL reset_probe got=%h exp=0", probe);
      end
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_busy got=%b exp=0", busy);
      end
      checks++;
      if (done !== 1'b0) begin
         failures++;
         $display("FAIL reset_done got=%b exp=0", done);
      end
      checks++;
      if (result !== 4'h0) begin
         failures++;
         $display("FAIL reset_result got=%h exp=0", result);
      end
      start = 1'b0;
      reset = 1'b1;
      tick();
   endtask

   task automatic test_reset_mid_search;
      logic saw_done;
      target = 4'sd5;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      checks++;
      if (busy !== 1'b0 || probe !== 4'h0 || done !== 1'b0) begin
         failures++;
         $display("FAIL midreset_idle got busy=%b probe=%h done=%b exp 0/0/0", busy, probe, done);
      end
      saw_done = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (done === 1'b1) saw_done = 1'b1;
      end
      checks++;
      if (saw_done !== 1'b0 || result !== 4'h0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL midreset_nodone got done_seen=%b result=%h busy=%b exp 0/0/0", saw_done, result, busy);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      checks++;
      if (done !== 1'b1 || result !== 4'h5) begin
         failures++;
         $display("FAIL midreset_restart got done=%b result=%h exp 1/5", done, result);
      end
      tick();
   endtask

   task automatic test_plus5;
      logic [W-1:0] exp_p [4];
      exp_p = '{4'hF, 4'h3, 4'h5, 4'h4};
      target = 4'sd5;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (probe !== exp_p[i] || busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL plus5_probe%0d got probe=%h busy=%b done=%b exp %h/1/0", i, probe, busy, done, exp_p[i]);
         end
         tick();
      end
      checks++;
      if (done !== 1'b1 || result !== 4'h5 || busy !== 1'b1 || probe !== 4'h0) begin
         failures++;
         $display("FAIL plus5_done got done=%b result=%h busy=%b probe=%h exp 1/5/1/0", done, result, busy, probe);
      end
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || result !== 4'h5) begin
         failures++;
         $display("FAIL plus5_idle got done=%b busy=%b result=%h exp 0/0/5", done, busy, result);
      end
   endtask

   task automatic test_extremes;
      int           ext_t [3];
      int           ext_p [3][4];
      logic [W-1:0] exp_v;
      ext_t = '{-8, 7, 0};
      ext_p = '{'{-1, -5, -7, -8}, '{-1, 3, 5, 6}, '{-1, 3, 1, 0}};
      for (int k = 0; k < 3; k++) begin
         target = W'(ext_t[k]);
         start = 1'b1;
         tick();
         start = 1'b0;
         for (int i = 0; i < 4; i++) begin
            exp_v = W'(ext_p[k][i]);
            checks++;
            if (probe !== exp_v) begin
               failures++;
               $display("FAIL extreme_t%0d_probe%0d got=%h exp=%h", ext_t[k], i, probe, exp_v);
            end
            tick();
         end
         exp_v = W'(ext_t[k]);
         checks++;
         if (done !== 1'b1 || result !== exp_v) begin
            failures++;
            $display("FAIL extreme_t%0d_result got done=%b result=%h exp 1/%h", ext_t[k], done, result, exp_v);
         end
         tick();
      end
   endtask

   task automatic test_start_busy;
      target = 4'sd5;
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (probe !== 4'hF) begin
         failures++;
         $display("FAIL busy_probe1 got=%h exp=f", probe);
      end
      tick();
      start = 1'b1;
      checks++;
      if (probe !== 4'h3) begin
         failures++;
         $display("FAIL busy_probe2 got=%h exp=3", probe);
      end
      tick();
      start = 1'b0;
      checks++;
      if (probe !== 4'h5) begin
         failures++;
         $display("FAIL busy_probe3 got=%h exp=5", probe);
      end
      tick();
      checks++;
      if (probe !== 4'h4) begin
         failures++;
         $display("FAIL busy_probe4 got=%h exp=4", probe);
      end
      tick();
      start = 1'b1;
      checks++;
      if (done !== 1'b1 || result !== 4'h5) begin
         failures++;
         $display("FAIL busy_done got done=%b result=%h exp 1/5", done, result);
      end
      tick();
      start = 1'b0;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || probe !== 4'h0) begin
         failures++;
         $display("FAIL busy_norestart got done=%b busy=%b probe=%h exp 0/0/0", done, busy, probe);
      end
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL busy_quiet got done=%b busy=%b exp 0/0", done, busy);
      end
   endtask

   task automatic test_back_to_back;
      logic [W-1:0] exp_v;
      start = 1'b1;
      for (int n = -8; n < 8; n++) begin
         target = W'(n);
         exp_v = W'(n);
         for (int c = 1; c <= 4; c++) begin
            tick();
            checks++;
            if (done !== 1'b0 || busy !== 1'b1) begin
               failures++;
               $display("FAIL b2b_t%0d_cyc%0d got done=%b busy=%b exp 0/1", n, c, done, busy);
            end
         end
         tick();
         checks++;
         if (done !== 1'b1 || result !== exp_v) begin
            failures++;
            $display("FAIL b2b_t%0d_result got done=%b result=%h exp 1/%h", n, done, result, exp_v);
         end
         tick();
         checks++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_t%0d_idle got done=%b busy=%b exp 0/0", n, done, busy);
         end
      end
      start = 1'b0;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      clk = 1'b0;
      reset = 1'b0;
      start = 1'b0;
      target = '0;
      checks = 0;
      failures = 0;
      #2;
      test_reset();
      test_reset_mid_search();
      test_plus5();
      test_extremes();
      test_start_busy();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
